serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
- Multi-cycle magnitude comparator for two WIDTH-bit operands.
- Operands arrive as a stream of 2-bit digit pairs, MSB digit first, under a valid/ready handshake.
- Produces registered eq/gt/lt flags and a one-cycle done pulse.
- Serves narrow datapaths where full-width operands are never assembled in parallel, such as serial links and digit-serial ALUs.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2.
- DIGITS, WIDTH/2, localparam: number of 2-bit digit beats per comparison.

Ports:
- clk      input   1  rising-edge clock
- rst_n    input   1  asynchronous active-low reset
- start    input   1  begin new comparison; honoured only in IDLE
- in_valid input   1  a_digit/b_digit valid this cycle
- in_ready output  1  block accepts a digit pair this cycle
- a_digit  input   2  current digit of operand A
- b_digit  input   2  current digit of operand B
- busy     output  1  high in RUN and DONE
- done     output  1  one-cycle pulse; flags valid from this cycle
- eq       output  1  A == B
- gt       output  1  A > B
- lt       output  1  A < B

Behaviour:
- Interface: one clock domain (clk); reset rst_n is asynchronous, active-low.
- Reset state: FSM=IDLE; in_ready, busy, done, eq, gt, lt all 0; digit counter 0; relation register EQ.
- FSM states: IDLE, RUN, DONE. All outputs are registered or decoded from state.
- IDLE:
  - in_ready=0.
  - start=1 -> RUN next cycle; counter=0; relation=EQ; eq/gt/lt cleared to 0.
- RUN:
  - in_ready=1, busy=1.
  - A beat is accepted only when in_valid && in_ready.
  - Per accepted beat: if relation==EQ, compare digits (a>b -> GT, a<b -> LT, else EQ). Once relation is GT or LT it is frozen; later digits are still consumed.
  - counter increments per accepted beat.
  - Accepting beat DIGITS-1 -> DONE. At that same edge, eq/gt/lt load the one-hot final relation, including the last beat's contribution.
- DONE:
  - Lasts one cycle; done=1, in_ready=0, busy=1.
  - Then -> IDLE.
  - Flags hold until the next accepted start.
- Latency: start sampled at edge 0; with in_valid held high, beats accepted at edges 1..DIGITS; done=1 during the cycle after edge DIGITS.
- Backpressure: in_valid low in RUN stalls the block indefinitely; state and counter are unchanged.
- start while busy (RUN or DONE): ignored; no effect on the in-flight result.
- start coincident with done: ignored; a new start is required in IDLE, so minimum spacing is one IDLE cycle.
- in_valid outside RUN: ignored; digits are not consumed.
- Exactly one of eq/gt/lt is high after done; all three are low between an accepted start and the next done.
- Asynchronous reset mid-operation: immediate return to reset state. The partial comparison is discarded and no done is issued.
- WIDTH=2: DIGITS=1; single beat, then DONE.

Optional Feature:
- Macro: SERIAL_CMP_SIGNED_EN.
- Defined: operands are two's complement. The first (MSB) digit is compared as signed 2-bit (-2..1); remaining digits compare unsigned.
- Undefined: all digits compare unsigned. No extra ports either way.

Test Plan:
- WIDTH=8, start, then beats A=0xA5 and B=0xA5 with in_valid held high -> done at cycle 5 after start; eq=1, gt=0, lt=0; flags hold for 10 idle cycles.
- A=0x80, B=0x7F -> unsigned build: gt=1. Build with SERIAL_CMP_SIGNED_EN: lt=1.
- A=0x3C, B=0x3D, in_valid low for 3 cycles between beats 1 and 2 -> in_ready stays 1, no beat lost; done at cycle 8 after start; lt=1.
- A=0xC0, B=0x40 with start re-pulsed during RUN and during DONE -> both ignored; single done; gt=1 (unsigned).
- rst_n low after beat 2 of 4, then release and run a fresh comparison A=0x01, B=0x02 -> no done from the aborted run; flags 0 until new done; then lt=1.
- Back-to-back: start in the first IDLE cycle after done, A=0xFF, B=0x00 -> previous flags cleared at the accepted start; new done gives gt=1.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Compares two WIDTH-bit operands that arrive as 2-bit digit pairs, MSB digit
// first, over a valid/ready handshake. The result appears on registered
// eq/gt/lt flags, and done pulses for one cycle when they become valid.
// Optional build macro: SERIAL_CMP_SIGNED_EN. When it is defined, the operands
// are two's complement and the leading digit is compared as a signed value.
module serial_magnitude_comparator #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] a_digit,
    input  logic [1:0] b_digit,
    output logic       busy,
    output logic       done,
    output logic       eq,
    output logic       gt,
    output logic       lt
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_GT = 2'd1,
        REL_LT = 2'd2
    } rel_t;

    state_t        state_q, state_d;
    rel_t          rel_q, rel_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          eq_q, eq_d;
    logic          gt_q, gt_d;
    logic          lt_q, lt_d;

    logic dig_gt, dig_lt;
    rel_t rel_next;

    // Compare the current digit pair; only the leading digit carries a sign.
    always_comb begin
        dig_gt = (a_digit > b_digit);
        dig_lt = (a_digit < b_digit);
`ifdef SERIAL_CMP_SIGNED_EN
        if (cnt_q == '0) begin
            dig_gt = ($signed(a_digit) > $signed(b_digit));
            dig_lt = ($signed(a_digit) < $signed(b_digit));
        end
`endif
    end

    // The relation is decided by the first unequal digit and then frozen.
    always_comb begin
        rel_next = rel_q;
        if (rel_q == REL_EQ) begin
            if (dig_gt)      rel_next = REL_GT;
            else if (dig_lt) rel_next = REL_LT;
            else             rel_next = REL_EQ;
        end
    end

    // Next-state logic: sequence IDLE -> RUN (one beat per handshake) -> DONE.
    always_comb begin
        state_d = state_q;
        rel_d   = rel_q;
        cnt_d   = cnt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        lt_d    = lt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rel_d   = REL_EQ;
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    lt_d    = 1'b0;
                end
            end
            S_RUN: begin
                // in_ready is high for the whole RUN state, so in_valid alone
                // marks an accepted beat.
                if (in_valid) begin
                    rel_d = rel_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_DONE;
                        eq_d    = (rel_next == REL_EQ);
                        gt_d    = (rel_next == REL_GT);
                        lt_d    = (rel_next == REL_LT);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers; reset discards any partial comparison.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rel_q   <= REL_EQ;
            cnt_q   <= '0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rel_q   <= rel_d;
            cnt_q   <= cnt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
            lt_q    <= lt_d;
        end
    end

    // Handshake and status outputs decode straight from the state register.
    always_comb begin
        in_ready = (state_q == S_RUN);
        busy     = (state_q != S_IDLE);
        done     = (state_q == S_DONE);
        eq       = eq_q;
        gt       = gt_q;
        lt       = lt_q;
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb_serial_magnitude_comparator
// Directed sequence with a scoreboard. Each comparison pushes its expected
// {eq,gt,lt} from an integer model, and every done pulse pops one entry and
// checks it.
module tb_serial_magnitude_comparator;
    localparam int W = 8;
    localparam int D = W / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] a_digit = 2'b00;
    logic [1:0] b_digit = 2'b00;
    logic       in_ready, busy, done, eq, gt, lt;

    int n_checks = 0;
    int n_pass   = 0;
    logic [2:0] exp_q[$];

    serial_magnitude_comparator #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a_digit(a_digit), .b_digit(b_digit),
        .busy(busy), .done(done), .eq(eq), .gt(gt), .lt(lt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference result as {eq,gt,lt}, computed on whole operands.
    function automatic logic [2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef SERIAL_CMP_SIGNED_EN
        if ($signed(a) > $signed(b)) return 3'b010;
        if ($signed(a) < $signed(b)) return 3'b001;
`else
        if (a > b) return 3'b010;
        if (a < b) return 3'b001;
`endif
        return 3'b100;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding comparison.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
            else chk("sb_flags", {29'd0, eq, gt, lt}, {29'd0, exp_q.pop_front()});
        end
    end

    // Assert start for one cycle starting at the next edge; afterwards the
    // block must be in RUN with its flags cleared.
    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("run_status", {29'd0, busy, in_ready, done}, 32'b110);
        chk("flags_cleared", {29'd0, eq, gt, lt}, 32'd0);
    endtask

    // Send nbeats digit pairs MSB first. stall_n idle cycles follow beat
    // stall_after, and start is re-asserted together with beat restart.
    task automatic feed(input logic [W-1:0] a, input logic [W-1:0] b, input int nbeats,
                        input int stall_after, input int stall_n, input int restart);
        for (int i = 0; i < nbeats; i++) begin
            a_digit  = a[W-1-2*i -: 2];
            b_digit  = b[W-1-2*i -: 2];
            in_valid = 1'b1;
            if (i == restart) start = 1'b1;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            if (i == stall_after) begin
                for (int k = 0; k < stall_n; k++) begin
                    @(posedge clk); #1;
                    chk("stall_status", {29'd0, in_ready, busy, done}, 32'b110);
                end
            end
        end
    endtask

    task automatic cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall_after, input int stall_n, input int restart);
        exp_q.push_back(model(a, b));
        do_start();
        feed(a, b, D, stall_after, stall_n, restart);
        // done must be high in the cycle right after the last accepted beat.
        chk("done_cycle", {29'd0, done, in_ready, busy}, 32'b101);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {26'd0, in_ready, busy, done, eq, gt, lt}, 32'd0);
        rst_n = 1'b1;

        // Equal operands, with no stalls.
        cmp(8'hA5, 8'hA5, -1, 0, -1);
        chk("t1_eq", {29'd0, eq, gt, lt}, 32'b100);
        // Flags must hold while idle, and in_valid in IDLE must be ignored.
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a_digit  = 2'(i);
            b_digit  = 2'(~i);
            @(posedge clk); #1;
            chk("t1_hold", {28'd0, busy, eq, gt, lt}, 32'b0100);
        end
        in_valid = 1'b0;

        // MSB digit decides the result; it flips in the signed build.
        cmp(8'h80, 8'h7F, -1, 0, -1);
`ifdef SERIAL_CMP_SIGNED_EN
        chk("t2_signed", {29'd0, eq, gt, lt}, 32'b001);
`else
        chk("t2_unsigned", {29'd0, eq, gt, lt}, 32'b010);
`endif

        // Three idle cycles after the first beat must not lose a beat.
        cmp(8'h3C, 8'h3D, 0, 3, -1);
        chk("t3_lt", {29'd0, eq, gt, lt}, 32'b001);

        // start during RUN (beat 2) and during DONE is ignored.
        cmp(8'hC0, 8'h40, -1, 0, 2);
        start = 1'b1;                 // held through the DONE cycle
        @(posedge clk); #1 start = 1'b0;
        chk("t4_idle_a", {30'd0, busy, done}, 32'd0);
        @(posedge clk); #1;
        chk("t4_idle_b", {30'd0, busy, done}, 32'd0);
`ifdef SERIAL_CMP_SIGNED_EN
        chk("t4_flags", {29'd0, eq, gt, lt}, 32'b001);
`else
        chk("t4_flags", {29'd0, eq, gt, lt}, 32'b010);
`endif

        // Asynchronous reset after 2 of 4 beats: no done, and all outputs clear.
        do_start();
        feed(8'hF0, 8'h0F, 2, -1, 0, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_outputs", {26'd0, in_ready, busy, done, eq, gt, lt}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", {26'd0, in_ready, busy, done, eq, gt, lt}, 32'd0);
        cmp(8'h01, 8'h02, -1, 0, -1);
        chk("t5_lt", {29'd0, eq, gt, lt}, 32'b001);

        // Back-to-back: start in the first IDLE cycle after done.
        cmp(8'hFF, 8'h00, -1, 0, -1);
`ifdef SERIAL_CMP_SIGNED_EN
        chk("t6_flags", {29'd0, eq, gt, lt}, 32'b001);
`else
        chk("t6_flags", {29'd0, eq, gt, lt}, 32'b010);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
